// File: rtl/spi_controller_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_controller_pkg;

  localparam int FRAME_W  = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // Reads carry a zero data byte so the peripheral sees a clean frame.
  function automatic logic [FRAME_W-1:0] build_frame(input logic              rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    return {rw, addr, (rw == RW_WRITE) ? data : {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command queue; a push into a full queue is accepted when a pop happens in the same cycle.
module spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 register-access master with command queue.
// Optional readback capture of cipo is enabled by defining READBACK_EN.
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              sclk,
  output logic              cs_n,
  output logic              copi,
  input  logic              cipo
);

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(CS_GAP - 1);

  state_t               state, state_nx;
  logic [7:0]           cnt, cnt_nx;
  logic [3:0]           bit_cnt, bit_cnt_nx;
  logic                 phase, phase_nx;
  logic [FRAME_W-1:0]   shreg, shreg_nx;
  logic                 rd_frame, rd_frame_nx;
  logic                 sample;
  logic                 done_c;
  logic                 err_c;

  logic [FRAME_W-1:0]   fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop_ok;
  logic                 head_ok;

  assign head_ok   = (fifo_head[FRAME_W-2 -: ADDR_W] < ADDR_W'(NUM_REGS));
  assign pop_ok    = !fifo_empty && ((state == IDLE) || (state == GAP && cnt == 8'd0));
  assign cmd_ready = !fifo_full || pop_ok;
  assign push      = cmd_valid && cmd_ready;

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_ok),
    .din   (build_frame(cmd_rw, cmd_addr, cmd_data)),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      shreg    <= '0;
      rd_frame <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      phase    <= phase_nx;
      shreg    <= shreg_nx;
      rd_frame <= rd_frame_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_cnt_nx  = bit_cnt;
    phase_nx    = phase;
    shreg_nx    = shreg;
    rd_frame_nx = rd_frame;
    sample      = 1'b0;
    done_c      = 1'b0;
    err_c       = 1'b0;
    unique case (state)
      IDLE: ;
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nx   = SHIFT;
          cnt_nx     = DIV_LD;
          phase_nx   = 1'b1;
          bit_cnt_nx = 4'd15;
          sample     = 1'b1;
        end else cnt_nx = cnt - 8'd1;
      end
      SHIFT: begin
        if (cnt != 8'd0) cnt_nx = cnt - 8'd1;
        else begin
          cnt_nx = DIV_LD;
          if (phase) begin
            // falling edge: present next bit; after bit 0 the last low half is HOLD
            phase_nx = 1'b0;
            shreg_nx = {shreg[FRAME_W-2:0], 1'b0};
            if (bit_cnt == 4'd0) state_nx = HOLD;
            else bit_cnt_nx = bit_cnt - 4'd1;
          end else begin
            phase_nx = 1'b1;
            sample   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LD;
        end else cnt_nx = cnt - 8'd1;
      end
      GAP: begin
        if (cnt == 8'd0) begin
          done_c   = 1'b1;
          state_nx = IDLE;
        end else cnt_nx = cnt - 8'd1;
      end
      default: state_nx = IDLE;
    endcase
    // Invalid addresses are consumed without touching the bus.
    if (pop_ok) begin
      if (head_ok) begin
        state_nx    = SETUP;
        cnt_nx      = DIV_LD;
        shreg_nx    = fifo_head;
        rd_frame_nx = (fifo_head[FRAME_W-1] == RW_READ);
      end else err_c = 1'b1;
    end
  end

  assign cs_n     = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign sclk     = (state == SHIFT) && phase;
  assign copi     = !cs_n && shreg[FRAME_W-1];
  assign busy     = (state != IDLE) || !fifo_empty;
  assign done     = done_c;
  assign addr_err = err_c;

`ifdef READBACK_EN
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rd_q;
  logic              load_rd;

  // rd_data must already hold the new byte in the done cycle.
  assign load_rd = rd_frame && (((state == HOLD) && (cnt == 8'd0) && (CS_GAP == 1)) ||
                                ((state == GAP) && (cnt == 8'd1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh <= '0;
      rd_q  <= '0;
    end else begin
      if (sample)  rx_sh <= {rx_sh[DATA_W-2:0], cipo};
      if (load_rd) rd_q  <= rx_sh;
    end
  end

  assign rd_data  = rd_q;
  assign rd_valid = done_c && rd_frame;
`else
  logic unused_rb;
  assign unused_rb = cipo ^ sample ^ rd_frame;
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
`endif

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 4..255, sized for the peripheral's 2-FF copi synchronizer.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: command queue entries; power of two, 2..16.
REQ-003 SHALL have parameter CS_GAP, default 2: minimum clk cycles cs_n stays high between frames, 1..15.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  queue can accept a command.
REQ-008 cmd_rw  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  7  target register address.
REQ-010 cmd_data  input  8  write data; don't-care for reads.
REQ-011 busy  output  1  frame in progress or queue non-empty.
REQ-012 done  output  1  one-cycle pulse per completed frame.
REQ-013 addr_err  output  1  one-cycle pulse per rejected command.
REQ-014 rd_data  output  8  last readback byte.
REQ-015 rd_valid  output  1  one-cycle pulse when rd_data updates.
REQ-016 sclk, cs_n, copi  output  1 each  SPI bus to peripheral; cipo  input  1  serial read data.

Function
REQ-017 Handshake: command accepted on a clk edge with cmd_valid && cmd_ready; cmd_ready = queue not full; same-cycle push and pop on a full queue SHALL accept the push.
REQ-018 Frame SHALL be 16 bits, MSB first: bit15 = cmd_rw, bits14:8 = cmd_addr, bits7:0 = cmd_data (zero for reads).
REQ-019 Commands with cmd_addr > 4 SHALL be accepted, then dropped at pop with addr_err pulsed, no bus activity, and no done pulse.
REQ-020 FSM states IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP the cycle after a valid entry is popped; cs_n low from SETUP entry.
REQ-021 SETUP SHALL last CLK_DIV cycles with sclk low and copi = bit15.
REQ-022 SHIFT SHALL produce 16 sclk periods (CLK_DIV high, CLK_DIV low); copi changes only at sclk falling edges, presenting the next lower bit; mode 0.
REQ-023 HOLD SHALL last CLK_DIV cycles after the 16th falling edge with cs_n low, then cs_n rises entering GAP.
REQ-024 GAP SHALL last CS_GAP cycles with cs_n high; done pulses on the last GAP cycle; then back-to-back pop to SETUP if queue non-empty, else IDLE.
REQ-025 sclk SHALL be low and copi 0 whenever cs_n is high.
REQ-026 Bit and divider counters SHALL never wrap mid-frame; frame length is fixed independent of queue activity.

Reset
REQ-027 Reset (asserted any time, including mid-frame) SHALL force cs_n=1, sclk=0, copi=0, done=0, addr_err=0, rd_valid=0, rd_data=0x00, FSM=IDLE, queue empty; cmd_ready=1 after deassertion.

Configuration
REQ-028 With READBACK_EN defined: for read frames, cipo sampled on the rising sclk edges of bits 7..0 into rd_data (MSB first); rd_data and rd_valid update in the done cycle.
REQ-029 Without READBACK_EN: cipo ignored, rd_data held 0x00, rd_valid held 0; read frames still transmitted.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding, FRAME_W=16, ADDR_W=7, DATA_W=8, NUM_REGS=5, and RW_WRITE=1 / RW_READ=0.
REQ-031 Command queue SHALL be a sub-module spi_cmd_fifo (synchronous, 16-bit entries, full/empty flags).

Verification
REQ-032 Write addr 0x00 data 0xFF -> exactly 16 rising sclk edges under cs_n low, sampled bits 0x80FF, one done pulse.
REQ-033 READBACK_EN, read addr 0x03, cipo model returns 0xA5 -> frame 0x0300, rd_data=0xA5 with rd_valid and done in same cycle.
REQ-034 Push 5 commands with cmd_valid held, FIFO_DEPTH=4 -> cmd_ready low after the queue fills, all 5 frames sent in order, cs_n high >= CS_GAP cycles between frames.
REQ-035 Write addr 0x07 then addr 0x01 data 0x3C -> addr_err pulse, no cs_n activity for the first, second frame 0x813C.
REQ-036 rst_n asserted after 8th sclk rising edge -> cs_n=1, sclk=0 immediately, busy=0, no done; next command sends a complete clean frame.
